alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle execute-stage ALU: registered result, valid/ready handshake on both sides, and the RV32M multiply/divide operations.
- Sits in the EX stage of the RISC-V pipeline.
- Base and multiply ops complete in 1 cycle; divide/remainder ops iterate one quotient bit per cycle.
- A destination tag travels with each operation so writeback can match results; a flush input kills in-flight work on a branch mispredict.

Parameters:
- DATA_WIDTH, 32, operand/result width (power of 2, >= 8)
- OPCODE_LENGTH, 5, width of Operation
- TAG_WIDTH, 5, width of the destination tag carried alongside the operation

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high
- flush  input  1  discard in-flight op and held result
- in_valid  input  1  operation present
- in_ready  output  1  operation accepted when in_valid & in_ready
- SrcA  input  DATA_WIDTH  operand A
- SrcB  input  DATA_WIDTH  operand B
- Operation  input  OPCODE_LENGTH  opcode (map below)
- in_tag  input  TAG_WIDTH  destination tag
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result when out_valid & out_ready
- ALUResult  output  DATA_WIDTH  registered result
- out_tag  output  TAG_WIDTH  tag of the held result
- busy  output  1  divide iteration in progress

Behaviour:
- Reset is asynchronous, active-high, on clk domain. On reset:
  - state=IDLE
  - out_valid=0, ALUResult=0, out_tag=0, busy=0
  - all divider registers cleared
- Opcode map:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SUB, 6 SRA
  - 7 SLT (signed), 8 EQ, 9 NE, 10 LT (signed), 11 GE (signed), 12 XOR
  - 13 LTU, 14 GEU
  - 15 MUL, 16 MULH, 17 MULHSU, 18 MULHU
  - 19 DIV, 20 DIVU, 21 REM, 22 REMU
  - 23-31 produce 0
- Arithmetic and width rules:
  - Compare ops return 1 or 0, zero-extended.
  - Shift amount = SrcB[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored.
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
  - MUL returns the low half of the 2*DATA_WIDTH product; the MULH variants return the high half with the named signedness.
- States:
  - IDLE: no result held.
  - HOLD: out_valid=1.
  - DIV_RUN: busy=1.
- in_ready = !flush & (state==IDLE | (state==HOLD & out_ready)).
- Accepting a non-divide op, or a divide early-out:
  - Next cycle: state=HOLD, ALUResult=result, out_tag=in_tag.
  - Latency is 1 cycle.
- Accepting a normal divide op:
  - Goes to DIV_RUN with a restoring radix-2 divider.
  - Operands are converted to magnitudes for signed ops.
  - Runs exactly DATA_WIDTH iteration cycles, then the sign-corrected result loads and the state goes to HOLD.
  - Latency is DATA_WIDTH+1 cycles from acceptance to out_valid.
- Divide early-outs (1-cycle latency):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give SrcA.
  - Signed overflow (SrcA = most-negative, SrcB = -1): DIV gives most-negative; REM gives 0.
- HOLD:
  - ALUResult and out_tag are stable while out_valid & !out_ready.
  - When out_ready is high and in_valid is low, go to IDLE.
  - A consume and an accept in the same cycle keep back-to-back throughput of 1 op/cycle.
- DIV_RUN: in_ready=0; SrcA, SrcB, Operation and in_tag are ignored until completion.
- Signed divide results:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- flush, sampled at a clk edge:
  - State goes to IDLE, out_valid=0, busy=0, and any divide in progress is abandoned.
  - No input is accepted that cycle.
  - ALUResult/out_tag keep their last values but are invalid.
- Reset mid-divide: abandoned immediately and asynchronously; no result is produced.
- out_valid never asserts without a matching prior acceptance, and each accepted op yields exactly one result unless flushed.

Test Plan:
- Reset then ADD 5+7, tag 3, out_ready=1 -> next cycle out_valid=1, ALUResult=12, out_tag=3; the following cycle out_valid=0.
- SLT A=0xFFFFFFFF, B=1 -> 1; LTU with the same operands -> 0; SRA 0x80000000 by B=0x21 -> 0xC0000000 (shift amount 1).
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same operands -> 0xFFFFFFFE; MUL -> 1; each completes in 1 cycle.
- DIV -7 / 2 -> busy for 32 cycles, out_valid in cycle 33 with 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; in_ready=0 throughout.
- DIVU 9/0 -> 0xFFFFFFFF in 1 cycle; REM 0x80000000 / 0xFFFFFFFF -> 0 in 1 cycle.
- Start DIV, assert flush at iteration 10 -> busy=0 and out_valid=0 next cycle, with no spurious result. Hold out_ready=0 for 3 cycles with a result held -> ALUResult stable, in_ready=0. Assert reset mid-divide -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with registered result, valid/ready on both
// sides, single-cycle base/multiply ops and an iterative radix-2 divider.
module alu_muldiv #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 5,
   parameter int unsigned TAG_WIDTH     = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [TAG_WIDTH-1:0]     in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic [TAG_WIDTH-1:0]     out_tag,
   output logic                     busy
);

   localparam int unsigned SHW = $clog2(DATA_WIDTH);
   localparam int unsigned CW  = $clog2(DATA_WIDTH);

   localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]         LAST_ITER = CW'(DATA_WIDTH - 1);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND    = OPCODE_LENGTH'(0);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR     = OPCODE_LENGTH'(1);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD    = OPCODE_LENGTH'(2);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL    = OPCODE_LENGTH'(3);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRL    = OPCODE_LENGTH'(4);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB    = OPCODE_LENGTH'(5);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA    = OPCODE_LENGTH'(6);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLT    = OPCODE_LENGTH'(7);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ     = OPCODE_LENGTH'(8);
   localparam logic [OPCODE_LENGTH-1:0] OP_NE     = OPCODE_LENGTH'(9);
   localparam logic [OPCODE_LENGTH-1:0] OP_LT     = OPCODE_LENGTH'(10);
   localparam logic [OPCODE_LENGTH-1:0] OP_GE     = OPCODE_LENGTH'(11);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR    = OPCODE_LENGTH'(12);
   localparam logic [OPCODE_LENGTH-1:0] OP_LTU    = OPCODE_LENGTH'(13);
   localparam logic [OPCODE_LENGTH-1:0] OP_GEU    = OPCODE_LENGTH'(14);
   localparam logic [OPCODE_LENGTH-1:0] OP_MUL    = OPCODE_LENGTH'(15);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULH   = OPCODE_LENGTH'(16);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHSU = OPCODE_LENGTH'(17);
   localparam logic [OPCODE_LENGTH-1:0] OP_MULHU  = OPCODE_LENGTH'(18);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIV    = OPCODE_LENGTH'(19);
   localparam logic [OPCODE_LENGTH-1:0] OP_DIVU   = OPCODE_LENGTH'(20);
   localparam logic [OPCODE_LENGTH-1:0] OP_REM    = OPCODE_LENGTH'(21);
   localparam logic [OPCODE_LENGTH-1:0] OP_REMU   = OPCODE_LENGTH'(22);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      DIV_RUN = 2'd2
   } state_t;

   state_t state;

   // divider working registers
   logic [DATA_WIDTH-1:0] dq;      // dividend shifting out, quotient shifting in
   logic [DATA_WIDTH-1:0] dr;      // partial remainder
   logic [DATA_WIDTH-1:0] dd;      // divisor magnitude
   logic [CW-1:0]         cnt;
   logic                  neg_q;
   logic                  neg_r;
   logic                  want_rem;
   logic [TAG_WIDTH-1:0]  div_tag;

   logic                  accept;
   logic [SHW-1:0]        shamt;
   logic                  sign_a;
   logic                  sign_b;
   logic [2*DATA_WIDTH-1:0] mul_a;
   logic [2*DATA_WIDTH-1:0] mul_b;
   logic [2*DATA_WIDTH-1:0] prod;
   logic [DATA_WIDTH-1:0] res;
   logic                  is_div_op;
   logic                  div_signed;
   logic                  div_zero;
   logic                  div_ovf;
   logic                  div_early;
   logic [DATA_WIDTH-1:0] mag_a;
   logic [DATA_WIDTH-1:0] mag_b;
   logic [DATA_WIDTH:0]   rs;
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] q_nxt;
   logic [DATA_WIDTH-1:0] r_nxt;
   logic [DATA_WIDTH-1:0] div_final;

   // ready when empty, or when the held result is being consumed this cycle
   assign in_ready = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
   assign accept   = in_valid && in_ready;
   assign shamt    = SrcB[SHW-1:0];

   // one shared 2W-bit multiplier; operand extension selects the signedness
   always_comb begin
      sign_a = (Operation == OP_MULH) || (Operation == OP_MULHSU);
      sign_b = (Operation == OP_MULH);
      mul_a  = {{DATA_WIDTH{sign_a & SrcA[DATA_WIDTH-1]}}, SrcA};
      mul_b  = {{DATA_WIDTH{sign_b & SrcB[DATA_WIDTH-1]}}, SrcB};
      prod   = mul_a * mul_b;
   end

   // divide classification and operand magnitudes
   always_comb begin
      is_div_op  = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
                   (Operation == OP_REM) || (Operation == OP_REMU);
      div_signed = (Operation == OP_DIV) || (Operation == OP_REM);
      div_zero   = (SrcB == '0);
      div_ovf    = div_signed && (SrcA == MIN_NEG) && (SrcB == '1);
      div_early  = is_div_op && (div_zero || div_ovf);
      mag_a      = (div_signed && SrcA[DATA_WIDTH-1]) ? -SrcA : SrcA;
      mag_b      = (div_signed && SrcB[DATA_WIDTH-1]) ? -SrcB : SrcB;
   end

   // single-cycle result; divide entries hold the early-out values only
   always_comb begin
      res = '0;
      case (Operation)
         OP_AND:    res = SrcA & SrcB;
         OP_OR:     res = SrcA | SrcB;
         OP_ADD:    res = SrcA + SrcB;
         OP_SLL:    res = SrcA << shamt;
         OP_SRL:    res = SrcA >> shamt;
         OP_SUB:    res = SrcA - SrcB;
         OP_SRA:    res = $unsigned($signed(SrcA) >>> shamt);
         OP_SLT:    res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_EQ:     res = DATA_WIDTH'(SrcA == SrcB);
         OP_NE:     res = DATA_WIDTH'(SrcA != SrcB);
         OP_LT:     res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_GE:     res = DATA_WIDTH'($signed(SrcA) >= $signed(SrcB));
         OP_XOR:    res = SrcA ^ SrcB;
         OP_LTU:    res = DATA_WIDTH'(SrcA < SrcB);
         OP_GEU:    res = DATA_WIDTH'(SrcA >= SrcB);
         OP_MUL:    res = prod[DATA_WIDTH-1:0];
         OP_MULH:   res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         OP_MULHSU: res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         OP_MULHU:  res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         OP_DIV:    res = div_zero ? '1 : MIN_NEG;
         OP_DIVU:   res = '1;
         OP_REM:    res = div_zero ? SrcA : '0;
         OP_REMU:   res = SrcA;
         default:   res = '0;
      endcase
   end

   // one restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      rs   = {dr, dq[DATA_WIDTH-1]};
      diff = rs - {1'b0, dd};
      if (diff[DATA_WIDTH]) begin
         r_nxt = rs[DATA_WIDTH-1:0];
         q_nxt = {dq[DATA_WIDTH-2:0], 1'b0};
      end else begin
         r_nxt = diff[DATA_WIDTH-1:0];
         q_nxt = {dq[DATA_WIDTH-2:0], 1'b1};
      end
      if (want_rem) begin
         div_final = neg_r ? -r_nxt : r_nxt;
      end else begin
         div_final = neg_q ? -q_nxt : q_nxt;
      end
   end

   // control FSM with registered outputs and divider datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         ALUResult <= '0;
         out_tag   <= '0;
         dq        <= '0;
         dr        <= '0;
         dd        <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         want_rem  <= 1'b0;
         div_tag   <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  if (is_div_op && !div_early) begin
                     state     <= DIV_RUN;
                     out_valid <= 1'b0;
                     busy      <= 1'b1;
                     dq        <= mag_a;
                     dr        <= '0;
                     dd        <= mag_b;
                     cnt       <= '0;
                     neg_q     <= div_signed && (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]);
                     neg_r     <= div_signed && SrcA[DATA_WIDTH-1];
                     want_rem  <= (Operation == OP_REM) || (Operation == OP_REMU);
                     div_tag   <= in_tag;
                  end else begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     ALUResult <= res;
                     out_tag   <= in_tag;
                  end
               end else if ((state == HOLD) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            DIV_RUN: begin
               dq  <= q_nxt;
               dr  <= r_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_ITER) begin
                  state     <= HOLD;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  ALUResult <= div_final;
                  out_tag   <= div_tag;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [4:0]  Operation;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic [4:0]  out_tag;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_muldiv dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Operation (Operation),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // reference model: RV32M semantics from plain integer arithmetic
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int          sa;
      int          sb;
      longint      pa;
      logic [63:0] pu;
      logic [4:0]  sh;
      logic        ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      sh  = b[4:0];
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      pu  = {32'b0, a} * {32'b0, b};
      case (op)
         5'd0:  return a & b;
         5'd1:  return a | b;
         5'd2:  return a + b;
         5'd3:  return a << sh;
         5'd4:  return a >> sh;
         5'd5:  return a - b;
         5'd6:  return 32'(sa >>> sh);
         5'd7:  return {31'b0, sa < sb};
         5'd8:  return {31'b0, a == b};
         5'd9:  return {31'b0, a != b};
         5'd10: return {31'b0, sa < sb};
         5'd11: return {31'b0, sa >= sb};
         5'd12: return a ^ b;
         5'd13: return {31'b0, a < b};
         5'd14: return {31'b0, a >= b};
         5'd15: return pu[31:0];
         5'd16: begin pa = longint'(sa) * longint'(sb); return pa[63:32]; end
         5'd17: begin pa = longint'(sa) * longint'({32'b0, b}); return pa[63:32]; end
         5'd18: return pu[63:32];
         5'd19: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         5'd20: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd21: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return 32'(sa % sb);
         end
         5'd22: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   // expected cycles from acceptance to out_valid
   function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      if (op < 5'd19 || op > 5'd22) return 1;
      if (b == 0) return 1;
      if ((op == 5'd19 || op == 5'd21) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // present one op and advance past its acceptance edge (stimulus only)
   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
      in_valid  = 1'b1;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_tag    = tag;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      SrcA = '0; SrcB = '0; Operation = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ALUResult); end
      checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_tag got %h want 0", out_tag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [4:0]  ops [6] = '{5'd7, 5'd13, 5'd6, 5'd16, 5'd18, 5'd15};
      logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs  [6] = '{32'h1, 32'h1, 32'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [6] = '{32'h1, 32'h0, 32'hC000_0000, 32'h0, 32'hFFFF_FFFE, 32'h1};
      out_ready = 1'b1;
      send(5'd2, 32'd5, 32'd7, 5'd3);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
      checks++; if (ALUResult !== 32'd12) begin errors++; $display("FAIL add_result got %h want c", ALUResult); end
      checks++; if (out_tag !== 5'd3) begin errors++; $display("FAIL add_tag got %h want 3", out_tag); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", out_valid); end
      for (int i = 0; i < 6; i++) begin
         send(ops[i], as[i], bs[i], 5'(i));
         checks++;
         if (out_valid !== 1'b1 || ALUResult !== exp[i]) begin
            errors++; $display("FAIL directed_op%0d valid %b result %h want %h", ops[i], out_valid, ALUResult, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div();
      out_ready = 1'b1;
      send(5'd19, 32'hFFFF_FFF9, 32'd2, 5'd9);
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; Operation = 5'd2; SrcA = $urandom; SrcB = $urandom; in_tag = 5'd1;
         checks++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL div_run_cycle%0d busy %b in_ready %b out_valid %b", i, busy, in_ready, out_valid);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFD || out_tag !== 5'd9 || busy !== 1'b0) begin
         errors++; $display("FAIL div_result valid %b result %h tag %h busy %b want fffffffd", out_valid, ALUResult, out_tag, busy);
      end
      @(posedge clk); #1;
      send(5'd21, 32'hFFFF_FFF9, 32'd2, 5'd10);
      repeat (32) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL rem_result valid %b result %h want ffffffff", out_valid, ALUResult);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_early_out();
      logic [4:0]  ops [4] = '{5'd20, 5'd21, 5'd19, 5'd22};
      logic [31:0] as  [4] = '{32'd9, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
      logic [31:0] bs  [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1234_5678};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(ops[i], as[i], bs[i], 5'(20 + i));
         checks++;
         if (out_valid !== 1'b1 || busy !== 1'b0 || ALUResult !== exp[i]) begin
            errors++; $display("FAIL early_op%0d valid %b busy %b result %h want %h", ops[i], out_valid, busy, ALUResult, exp[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic spurious;
      out_ready = 1'b1;
      send(5'd19, 32'd100, 32'd3, 5'd4);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      in_valid = 1'b1; Operation = 5'd2; SrcA = 32'd1; SrcB = 32'd1; in_tag = 5'd5;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_div busy %b out_valid %b want 0 0", busy, out_valid);
      end
      spurious = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
      end
      checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL flush_spurious got %b want 0", spurious); end
      // flush a held result: invalidated but value retained
      out_ready = 1'b0;
      send(5'd2, 32'd1, 32'd2, 5'd7);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || ALUResult !== 32'd3 || out_tag !== 5'd7) begin
         errors++; $display("FAIL flush_hold valid %b result %h tag %h want 0 3 7", out_valid, ALUResult, out_tag);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_hold_stall();
      out_ready = 1'b0;
      send(5'd12, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5'd11);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || ALUResult !== 32'hAA55_F0F0 || out_tag !== 5'd11 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_cycle%0d valid %b result %h tag %h in_ready %b", i, out_valid, ALUResult, out_tag, in_ready);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = 5'($urandom_range(0, 18));
         a = rand_operand();
         b = rand_operand();
         exp = ref_alu(op, a, b);
         in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; in_tag = 5'(i);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || ALUResult !== exp || out_tag !== 5'(i)) begin
            errors++; $display("FAIL b2b_result%0d op %0d valid %b got %h want %h tag %h", i, op, out_valid, ALUResult, exp, out_tag);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [4:0]  tag;
      int          lat;
      int          want_lat;
      logic        stall_bad;
      out_ready = 1'b1;
      for (int n = 0; n < 250; n++) begin
         op  = 5'($urandom_range(0, 31));
         a   = rand_operand();
         b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : rand_operand();
         tag = 5'($urandom);
         exp = ref_alu(op, a, b);
         want_lat = ref_latency(op, a, b);
         send(op, a, b, tag);
         lat = 1;
         stall_bad = 1'b0;
         while (out_valid !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
         end
         checks++;
         if (lat !== want_lat || stall_bad) begin
            errors++; $display("FAIL rand_latency op %0d a %h b %h got %0d want %0d busy_err %b", op, a, b, lat, want_lat, stall_bad);
         end
         checks++;
         if (out_valid !== 1'b1 || ALUResult !== exp || out_tag !== tag) begin
            errors++; $display("FAIL rand_result op %0d a %h b %h got %h want %h tag %h/%h", op, a, b, ALUResult, exp, out_tag, tag);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_div();
      out_ready = 1'b1;
      send(5'd20, 32'hDEAD_BEEF, 32'd7, 5'd15);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || ALUResult !== 32'h0 || out_tag !== 5'h0) begin
         errors++; $display("FAIL reset_mid_div busy %b valid %b result %h tag %h", busy, out_valid, ALUResult, out_tag);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_result got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div();
      test_early_out();
      test_flush();
      test_hold_stall();
      test_back_to_back();
      test_random();
      test_reset_mid_div();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "timeout");
   end

endmodule
